imem_load_ctrl: RTL and testbench

//  Sequences the instruction memory between two users: CPU fetch (combinational read) and a

---
 rtl/imem_pkg.sv | 19 +
 rtl/byte_to_word.sv | 42 ++++
 rtl/imem_load_ctrl.sv | 155 +++++++++++++++
 tb/tb_imem_load_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
//   state_t   : controller sequencing states
//   NOP       : word returned to fetch while loading or on a bad fetch address
//   DEPTH_DEF : default imem depth in words
//   AW_DEF    : default word-address width (log2 of DEPTH_DEF)
package imem_pkg;

  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned AW_DEF    = 6;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_to_word.sv
// Assembles a little-endian byte stream into 32-bit words.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : restart assembly at lane 0, dropping any partial word
//   byte_valid   : byte_data is accepted this cycle
//   byte_data    : incoming byte, first byte of a word lands in bits [7:0]
//   word_valid_c : combinational, high on the cycle the 4th byte is accepted
//   word_c       : combinational, assembled word (valid with word_valid_c)
module byte_to_word
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid_c,
  output logic [31:0] word_c
);

  logic [1:0]  byte_cnt;
  logic [23:0] lanes;

  // Lane counter and lower three lanes; the 4th byte bypasses straight into word_c.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    lanes[7:0]   <= byte_data;
        2'd1:    lanes[15:8]  <= byte_data;
        2'd2:    lanes[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  assign word_valid_c = byte_valid && (byte_cnt == 2'd3);
  assign word_c       = {byte_data, lanes};

endmodule

// File: rtl/imem_load_ctrl.sv
// Arbitrates the instruction memory between CPU fetch and a byte-stream loader.
//   clk, reset        : clock, synchronous active-high reset
//   pc / instr        : CPU fetch byte address / instruction (instr combinational)
//   fetch_err         : registered pulse for a misaligned or out-of-range pc
//   cpu_hold          : registered core hold while a load is in progress
//   ld_start, ld_len  : begin a load of ld_len words (accepted only in RUN)
//   ld_valid, ld_data : byte stream, LSB-first per word
//   ld_ready          : byte accepted when ld_valid & ld_ready
//   ld_busy           : load sequence in progress
//   ld_err            : sticky bad-length flag, cleared by the next good start
//   mem_raddr/rdata   : imem combinational read port
//   mem_we/waddr/wdata: registered imem write port
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          fetch_err,
  output logic          cpu_hold,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_err,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata
);

  localparam int unsigned LW = AW + 1;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] word_cnt;

  logic          bad_pc_c;
  logic          len_ok_c;
  logic          start_c;
  logic          go_load_c;
  logic          accept_c;
  logic          word_valid_c;
  logic [31:0]   word_c;
  logic          last_word_c;

  logic          cpu_hold_d;
  logic          ld_ready_d;
  logic          ld_busy_d;

  // Fetch address decode and load qualification.
  assign bad_pc_c    = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
  assign len_ok_c    = (ld_len != '0) && (ld_len <= LW'(DEPTH));
  assign start_c     = (state == RUN) && ld_start;
  assign go_load_c   = start_c && len_ok_c;
  assign accept_c    = ld_valid && ld_ready;
  // word_cnt counts words already written, so it equals len-1 on the final word.
  assign last_word_c = word_valid_c && (word_cnt == (len_q - LW'(1)));

  assign mem_raddr = pc[AW+1:2];
  assign instr     = ((state == RUN) && !bad_pc_c) ? mem_rdata : NOP;

  byte_to_word u_b2w (
    .clk          (clk),
    .reset        (reset),
    .clear        (go_load_c),
    .byte_valid   (accept_c),
    .byte_data    (ld_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (go_load_c) state_nxt = LOAD;
      LOAD:    if (last_word_c) state_nxt = RELEASE;
      RELEASE: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output decode from the upcoming state so the registered flags track it exactly;
  // ld_ready therefore drops on the edge that takes the last byte.
  always_comb begin
    cpu_hold_d = 1'b0;
    ld_ready_d = 1'b0;
    ld_busy_d  = 1'b0;
    case (state_nxt)
      LOAD: begin
        cpu_hold_d = 1'b1;
        ld_ready_d = 1'b1;
        ld_busy_d  = 1'b1;
      end
      RELEASE: begin
        cpu_hold_d = 1'b1;
        ld_busy_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs, word counter and write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold  <= 1'b0;
      ld_ready  <= 1'b0;
      ld_busy   <= 1'b0;
      ld_err    <= 1'b0;
      fetch_err <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      len_q     <= '0;
    end else begin
      cpu_hold  <= cpu_hold_d;
      ld_ready  <= ld_ready_d;
      ld_busy   <= ld_busy_d;
      fetch_err <= (state == RUN) && bad_pc_c;
      mem_we    <= word_valid_c;
      if (start_c) begin
        ld_err <= !len_ok_c;
      end
      if (go_load_c) begin
        len_q    <= ld_len;
        word_cnt <= '0;
      end
      if (word_valid_c) begin
        mem_waddr <= word_cnt[AW-1:0];
        mem_wdata <= word_c;
        word_cnt  <= word_cnt + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed sequence plus randomized loads
// checked against a word-level model of the memory image.
module tb_imem_load_ctrl;
  import imem_pkg::*;

  localparam int unsigned D = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        fetch_err;
  logic        cpu_hold;
  logic        ld_start;
  logic [6:0]  ld_len;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_err;
  logic [5:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;

  logic [31:0] tb_mem  [D];
  logic [31:0] ref_mem [D];
  logic        init_mem;
  logic [5:0]  wr_a [$];
  logic [31:0] wr_d [$];

  logic [7:0]  t2 [8] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h8F, 8'h00, 8'h00};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .fetch_err (fetch_err),
    .cpu_hold  (cpu_hold),
    .ld_start  (ld_start),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_err    (ld_err),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Behavioural imem: combinational read, write on the clock edge, every write logged.
  assign mem_rdata = tb_mem[mem_raddr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < D; k++) tb_mem[k] <= ref_mem[k];
    end else if (mem_we) begin
      tb_mem[mem_waddr] <= mem_wdata;
      wr_a.push_back(mem_waddr);
      wr_d.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int k = 0; k < D; k++) if (tb_mem[k] !== ref_mem[k]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // Load len random words with random ld_valid gaps; expected words come from the byte list.
  task automatic run_load(input int len, input int gap_pct, input string tag);
    logic [7:0]  b [$];
    logic [31:0] w;
    int          base;
    int          n;
    base = wr_a.size();
    for (int i = 0; i < 4 * len; i++) b.push_back(8'($urandom));
    ld_start = 1'b1;
    ld_len   = 7'(len);
    tick();
    ld_start = 1'b0;
    check({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
    check({tag, "_err_clr"}, 32'(ld_err), 32'd0);
    for (int i = 0; i < 4 * len; i++) begin
      n = 0;
      while (int'($urandom_range(99)) < gap_pct && n < 8) begin
        ld_valid = 1'b0;
        tick();
        n++;
      end
      ld_valid = 1'b1;
      ld_data  = b[i];
      n = 0;
      while (!ld_ready && n < 50) begin
        tick();
        n++;
      end
      if (!ld_ready) check({tag, "_ready_wait"}, 32'(ld_ready), 32'd1);
      tick();
    end
    ld_valid = 1'b0;
    check({tag, "_ready_drop"}, 32'(ld_ready), 32'd0);
    check({tag, "_hold_release"}, 32'(cpu_hold), 32'd1);
    tick();
    check({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy_off"}, 32'(ld_busy), 32'd0);
    check({tag, "_nwrites"}, 32'(wr_a.size() - base), 32'(len));
    for (int j = 0; j < len; j++) begin
      w = {b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]};
      ref_mem[j] = w;
      if (base + j < wr_a.size()) begin
        check({tag, "_waddr"}, 32'(wr_a[base+j]), 32'(j));
        check({tag, "_wdata"}, wr_d[base+j], w);
      end
    end
    check_image({tag, "_image"});
  endtask

  initial begin
    int          base;
    logic [7:0]  b6 [6];

    reset    = 1'b1;
    pc       = 32'h8;
    ld_start = 1'b0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    for (int k = 0; k < D; k++) ref_mem[k] = $urandom;
    ref_mem[2] = 32'hFF71_8393;
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0;
    tick();

    // Reset values
    check("rst_hold",   32'(cpu_hold),  32'd0);
    check("rst_ferr",   32'(fetch_err), 32'd0);
    check("rst_ready",  32'(ld_ready),  32'd0);
    check("rst_busy",   32'(ld_busy),   32'd0);
    check("rst_lderr",  32'(ld_err),    32'd0);
    check("rst_we",     32'(mem_we),    32'd0);
    check("rst_waddr",  32'(mem_waddr), 32'd0);
    check("rst_wdata",  mem_wdata,      32'd0);
    reset = 1'b0;
    tick();
    check("fetch_pc8",  instr,          32'hFF71_8393);
    check("fetch_ferr", 32'(fetch_err), 32'd0);

    // Directed two-word load with an ignored restart
    base = wr_a.size();
    ld_start = 1'b1;
    ld_len   = 7'd2;
    tick();
    ld_start = 1'b0;
    check("t2_hold",  32'(cpu_hold), 32'd1);
    check("t2_busy",  32'(ld_busy),  32'd1);
    check("t2_ready", 32'(ld_ready), 32'd1);
    pc = 32'h4;
    #1;
    check("t2_instr_nop", instr, NOP);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_data  = t2[i];
      if (i == 0) begin
        ld_start = 1'b1;
        ld_len   = 7'd1;
      end
      tick();
      ld_start = 1'b0;
      if (i == 3) begin
        check("t2_we0",    32'(mem_we),    32'd1);
        check("t2_waddr0", 32'(mem_waddr), 32'd0);
        check("t2_wdata0", mem_wdata,      32'h0050_0113);
        check("t2_hold_mid", 32'(cpu_hold), 32'd1);
      end
      if (i == 4) check("t2_we_gap", 32'(mem_we), 32'd0);
      if (i == 6) check("t2_ready_mid", 32'(ld_ready), 32'd1);
    end
    ld_valid = 1'b0;
    check("t2_we1",     32'(mem_we),    32'd1);
    check("t2_waddr1",  32'(mem_waddr), 32'd1);
    check("t2_wdata1",  mem_wdata,      32'h0000_8F93);
    check("t2_ready0",  32'(ld_ready),  32'd0);
    check("t2_hold_rel", 32'(cpu_hold), 32'd1);
    check("t2_busy_rel", 32'(ld_busy),  32'd1);
    tick();
    check("t2_hold_off", 32'(cpu_hold), 32'd0);
    check("t2_busy_off", 32'(ld_busy),  32'd0);
    check("t2_we_off",   32'(mem_we),   32'd0);
    check("t2_nwrites",  32'(wr_a.size() - base), 32'd2);
    check("t2_lderr",    32'(ld_err),   32'd0);
    ref_mem[0] = 32'h0050_0113;
    ref_mem[1] = 32'h0000_8F93;
    pc = 32'h0;
    #1;
    check("t2_fetch0", instr, 32'h0050_0113);
    pc = 32'h4;
    #1;
    check("t2_fetch1", instr, 32'h0000_8F93);
    check_image("t2_image");

    // Bad lengths: error flag only, no hold, no writes
    base = wr_a.size();
    ld_len   = 7'd0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("len0_err",  32'(ld_err),   32'd1);
    check("len0_hold", 32'(cpu_hold), 32'd0);
    check("len0_busy", 32'(ld_busy),  32'd0);
    tick();
    check("len0_sticky", 32'(ld_err), 32'd1);
    check("len0_we",     32'(mem_we), 32'd0);
    ld_len   = 7'd65;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("len65_err",  32'(ld_err),   32'd1);
    check("len65_hold", 32'(cpu_hold), 32'd0);
    tick();
    check("badlen_nwrites", 32'(wr_a.size() - base), 32'd0);
    run_load(1, 0, "len1");

    // Bad fetch addresses and the last valid word
    pc = 32'h6;
    #1;
    check("pc6_instr", instr, NOP);
    tick();
    check("pc6_ferr", 32'(fetch_err), 32'd1);
    pc = 32'h100;
    #1;
    check("pc100_instr", instr, NOP);
    tick();
    check("pc100_ferr", 32'(fetch_err), 32'd1);
    pc = 32'hFC;
    #1;
    check("pcfc_instr", instr, ref_mem[63]);
    tick();
    check("pcfc_ferr", 32'(fetch_err), 32'd0);

    // Reset after 6 of 8 bytes
    base = wr_a.size();
    ld_len   = 7'd2;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b6[i]    = 8'($urandom);
      ld_valid = 1'b1;
      ld_data  = b6[i];
      tick();
    end
    ld_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check("mid_rst_hold",  32'(cpu_hold), 32'd0);
    check("mid_rst_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_we",    32'(mem_we),   32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("mid_rst_busy",    32'(ld_busy), 32'd0);
    check("mid_rst_nwrites", 32'(wr_a.size() - base), 32'd1);
    if (wr_a.size() > base) begin
      check("mid_rst_waddr", 32'(wr_a[base]), 32'd0);
      check("mid_rst_wdata", wr_d[base], {b6[3], b6[2], b6[1], b6[0]});
    end
    ref_mem[0] = {b6[3], b6[2], b6[1], b6[0]};
    check_image("mid_rst_image");

    // Randomized loads with gaps, including a full-depth load
    run_load(int'($urandom_range(3, 8)), 40, "gap");
    run_load(int'($urandom_range(1, 12)), 0, "b2b");
    run_load(64, 20, "full");
    pc = 32'hFC;
    #1;
    check("full_fetch63", instr, ref_mem[63]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
